// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial pattern transmitter, MSB-first, with repeat count and inter-repetition gap
module pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [CNT_W-1:0] repeat_i,
  input  logic [CNT_W-1:0] gap_i,
  output logic             w_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             w_q, w_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_eff;
  logic [CNT_W-1:0] rep_eff;

  always_comb begin
    len_eff = (len_i > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len_i;
    rep_eff = (repeat_i == '0) ? CNT_W'(1) : repeat_i;
  end

  // rep_q counts repetitions still owed, including the one being sent.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pat_d  = pattern_i;
          len_d  = len_eff;
          rep_d  = rep_eff;
          gap_d  = gap_i;
          gcnt_d = '0;
          idx_d  = IDX_W'(len_eff - LEN_W'(1));
          state_d = (len_eff == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (idx_q == '0) begin
          if (rep_q > CNT_W'(1)) begin
            rep_d = rep_q - CNT_W'(1);
            if (gap_q != '0) begin
              state_d = S_GAP;
              gcnt_d  = gap_q;
            end else begin
              idx_d = IDX_W'(len_q - LEN_W'(1));
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q <= CNT_W'(1)) begin
          state_d = S_SEND;
          gcnt_d  = '0;
          idx_d   = IDX_W'(len_q - LEN_W'(1));
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    w_d     = (state_d == S_SEND) && pat_d[idx_d];
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w_o     = w_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - self-checking bench for pattern_tx against a cycle-list reference model
module tb_pattern_tx;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] rpt;
  logic [3:0] gap;
  logic       w;
  logic       valid;
  logic       busy;
  logic       done;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [3:0] exp_q[$];

  pattern_tx #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .pattern_i (pattern),
    .len_i     (len),
    .repeat_i  (rpt),
    .gap_i     (gap),
    .w_o       (w),
    .valid_o   (valid),
    .busy_o    (busy),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {w,valid,busy,done} per cycle after the start edge, plus one trailing idle cycle.
  task automatic build_exp(input logic [7:0] p, input int l, input int r, input int g);
    int le;
    int re;
    exp_q.delete();
    le = (l > 8) ? 8 : l;
    re = (r == 0) ? 1 : r;
    if (le != 0) begin
      for (int k = 0; k < re; k++) begin
        for (int b = le - 1; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
        if (k < re - 1)
          for (int j = 0; j < g; j++) exp_q.push_back(4'b0010);
      end
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic run_check(input string name, input logic [7:0] p, input int l, input int r,
                           input int g, input bit perturb);
    logic [3:0] obs;
    build_exp(p, l, r, g);
    @(negedge clk);
    start = 1'b1; pattern = p; len = 4'(l); rpt = 4'(r); gap = 4'(g);
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs = {w, valid, busy, done};
      cmp_cnt++;
      if (obs !== exp_q[i]) begin
        err_cnt++;
        $display("FAIL %s cycle %0d: got w/v/b/d=%b required %b", name, i + 1, obs, exp_q[i]);
      end
      start = perturb && (i == 1 || i == 2);
      if (perturb) begin
        pattern = 8'($urandom);
        len = 4'($urandom);
        rpt = 4'($urandom);
        gap = 4'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; pattern = '0; len = '0; rpt = '0; gap = '0;
    #12;
    cmp_cnt++;
    if ({w, valid, busy, done} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_hold: got %b required 0000", {w, valid, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if ({w, valid, busy, done} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_idle: got %b required 0000", {w, valid, busy, done});
    end
  endtask

  task automatic test_basic;
    run_check("basic_1101", 8'b0000_1101, 4, 1, 0, 1'b0);
  endtask

  task automatic test_repeat_gap;
    run_check("repeat_gap", 8'b0000_1101, 4, 2, 2, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_check("back_to_back", 8'b0000_1101, 4, 3, 0, 1'b0);
    run_check("repeat_zero", 8'b1010_0110, 3, 0, 5, 1'b0);
  endtask

  task automatic test_len_bounds;
    run_check("len_zero", 8'hA5, 0, 3, 2, 1'b0);
    run_check("len_clamp", 8'b1001_0110, 12, 1, 0, 1'b0);
    run_check("len_one", 8'h01, 1, 2, 1, 1'b0);
  endtask

  task automatic test_start_ignored;
    run_check("start_ignored", 8'b0000_1101, 4, 2, 1, 1'b1);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    start = 1'b1; pattern = 8'b0000_1101; len = 4'd4; rpt = 4'd1; gap = 4'd0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2;
    cmp_cnt++;
    if ({w, valid, busy, done} !== 4'b1110) begin
      err_cnt++;
      $display("FAIL mid_reset_pre: got %b required 1110", {w, valid, busy, done});
    end
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({w, valid, busy, done} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL mid_reset_async: got %b required 0000", {w, valid, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({w, valid, busy, done} !== 4'b0000) begin
        err_cnt++;
        $display("FAIL mid_reset_after cycle %0d: got %b required 0000", i, {w, valid, busy, done});
      end
    end
    run_check("post_reset", 8'b0000_1101, 4, 1, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      run_check("random", 8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat_gap();
    test_back_to_back();
    test_len_bounds();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
